// File: rtl/lcdc_pkg.sv
// Shared types and sizing helpers for the 8080-style LCD controller.
package lcdc_pkg;

   typedef enum logic [2:0] {
      ST_RST,
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } lcdc_state_e;

   // Command entry is {rd, rs, data}.
   function automatic int entry_width(input int dw);
      return dw + 2;
   endfunction

   // Counter holds (cycles - 1), so the widest phase needs clog2(max) bits, never fewer than 1.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/lcdc_cmd_fifo.sv
// Synchronous command FIFO with occupancy level; head is visible combinationally.
// Latency: an entry pushed on one edge is at the head after that edge.
// Backpressure: push_rdy is registered and drops while full; a pop while full reopens it a cycle later.
module lcdc_cmd_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push_vld,
   output logic                     push_rdy,
   input  logic [WIDTH-1:0]         push_dat,
   output logic                     head_vld,
   input  logic                     head_rdy,
   output logic [WIDTH-1:0]         head_dat,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic [LW-1:0]    lvl_nxt;
   logic             do_push, do_pop;

   assign do_push  = push_vld && push_rdy;
   assign do_pop   = head_rdy && head_vld;
   assign head_vld = (level != '0);
   assign head_dat = mem[rptr];

   always_comb begin
      lvl_nxt = level;
      if (do_push && !do_pop)
         lvl_nxt = level + 1'b1;
      else if (!do_push && do_pop)
         lvl_nxt = level - 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         push_rdy <= 1'b0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         level    <= lvl_nxt;
         push_rdy <= (lvl_nxt != LW'(DEPTH));
      end
   end

   // Storage is not reset; pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= push_dat;
   end

endmodule

// File: rtl/lcdc_8080_fifo.sv
// 8080-style LCD bus master fed by a command FIFO, with panel reset pulse generation.
// Latency: strobe falls 1 + SETUP_CYC cycles after a push into an idle controller.
// Backpressure: in_ready follows FIFO fullness; reads return on rdata_valid with no stall.
module lcdc_8080_fifo
   import lcdc_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int SETUP_CYC  = 1,
   parameter int PULSE_CYC  = 2,
   parameter int HOLD_CYC   = 1,
   parameter int RST_CYC    = 1024
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_rd,
   input  logic                          in_rs,
   input  logic [DATA_WIDTH-1:0]         in_data,
   output logic                          rdata_valid,
   output logic [DATA_WIDTH-1:0]         rdata,
   input  logic                          rst_req,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          lcdc_rst_n,
   output logic                          lcdc_cs_n,
   output logic                          lcdc_rs,
   output logic                          lcdc_wr_n,
   output logic                          lcdc_rd_n,
   output logic [DATA_WIDTH-1:0]         lcdc_d_out,
   output logic                          lcdc_d_oe,
   input  logic [DATA_WIDTH-1:0]         lcdc_d_in
);

   localparam int ENTRY_W = entry_width(DATA_WIDTH);
   localparam int CNT_W   = cnt_width(RST_CYC, SETUP_CYC, PULSE_CYC, HOLD_CYC);

   localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'(RST_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_PULSE = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_HOLD  = CNT_W'(HOLD_CYC - 1);

   typedef struct packed {
      logic                  rd;
      logic                  rs;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   entry_t           push_ent, head, txn;
   logic             head_vld, pop;
   lcdc_state_e      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   assign push_ent = {in_rd, in_rs, in_data};

   lcdc_cmd_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push_vld (in_valid),
      .push_rdy (in_ready),
      .push_dat (push_ent),
      .head_vld (head_vld),
      .head_rdy (pop),
      .head_dat (head),
      .level    (fifo_level)
   );

   assign busy       = (state != ST_IDLE) || head_vld;
   assign lcdc_rs    = txn.rs;
   assign lcdc_d_out = txn.data;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pop       = 1'b0;
      case (state)
         ST_RST: begin
            if (cnt == '0) state_nxt = ST_IDLE;
            else           cnt_nxt   = cnt - 1'b1;
         end
         ST_IDLE: begin
            if (rst_req) begin
               state_nxt = ST_RST;
               cnt_nxt   = CNT_RST;
            end else if (head_vld) begin
               pop       = 1'b1;
               state_nxt = ST_SETUP;
               cnt_nxt   = CNT_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt == '0) begin
               state_nxt = ST_STROBE;
               cnt_nxt   = CNT_PULSE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_STROBE: begin
            if (cnt == '0) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = CNT_HOLD;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else if (rst_req) begin
               state_nxt = ST_RST;
               cnt_nxt   = CNT_RST;
            end else if (head_vld) begin
               // Back-to-back: chip select stays asserted into the next SETUP.
               pop       = 1'b1;
               state_nxt = ST_SETUP;
               cnt_nxt   = CNT_SETUP;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_RST;
            cnt_nxt   = CNT_RST;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_RST;
         cnt         <= CNT_RST;
         txn         <= '0;
         lcdc_d_oe   <= 1'b0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         lcdc_rst_n  <= 1'b0;
         lcdc_cs_n   <= 1'b1;
         lcdc_wr_n   <= 1'b1;
         lcdc_rd_n   <= 1'b1;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         rdata_valid <= 1'b0;
         if (pop) begin
            txn.rd <= head.rd;
            txn.rs <= head.rs;
            if (!head.rd) txn.data <= head.data;
            lcdc_d_oe <= !head.rd;
         end else if (state_nxt == ST_IDLE || state_nxt == ST_RST) begin
            lcdc_d_oe <= 1'b0;
         end
         if (state == ST_STROBE && cnt == '0 && txn.rd) begin
            rdata       <= lcdc_d_in;
            rdata_valid <= 1'b1;
         end
         // Pins are registered from the next state so they switch glitch-free with it.
         lcdc_rst_n <= (state_nxt != ST_RST);
         lcdc_cs_n  <= !(state_nxt == ST_SETUP || state_nxt == ST_STROBE || state_nxt == ST_HOLD);
         lcdc_wr_n  <= !(state_nxt == ST_STROBE && !txn.rd);
         lcdc_rd_n  <= !(state_nxt == ST_STROBE && txn.rd);
      end
   end

endmodule
